// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_DATA_W   = 32;
  localparam int READ_LATENCY = 3;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } tag_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/onchip_mem_arb_rr.sv
// Two-way round-robin picker: combinational one-hot grant plus the last-granted pointer.
module onchip_mem_arb_rr
  import onchip_mem_arb_pkg::*;
#(
  parameter bit INIT_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  master_id_t last_q;
  master_id_t last_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (grant_o[1]) begin
      last_d = 1'b1;
    end else if (grant_o[0]) begin
      last_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= INIT_LAST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter in front of a single-port RAM, fixed 3-cycle read return tagged per master.
// Build with MEM_ARB_STATS_EN defined to add saturating grant/conflict counters.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter bit INIT_LAST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_grant0,
  output logic [31:0]         stat_grant1,
  output logic [31:0]         stat_conflict
`endif
);

  localparam int BE_W      = DATA_W / 8;
  localparam int CAP_STAGE = READ_LATENCY - 2;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              any_grant;
  master_id_t        win_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [BE_W-1:0]   be_q,    be_d;
  logic              cs_q,    cs_d;
  logic              wr_q,    wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  tag_t              tag_q [READ_LATENCY];
  tag_t              tag_new;
  logic [DATA_W-1:0] rd0_q, rd1_q;

  // A simultaneous read+write from one master counts as a single write request.
  assign req = {m1_read | m1_write, m0_read | m0_write};

  onchip_mem_arb_rr #(
    .INIT_LAST(INIT_LAST)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req),
    .grant_o(grant)
  );

  assign any_grant = |grant;
  assign win_id    = grant[1];
  assign sel_write = win_id ? m1_write      : m0_write;
  assign sel_addr  = win_id ? m1_address    : m0_address;
  assign sel_be    = win_id ? m1_byteenable : m0_byteenable;
  assign sel_wdata = win_id ? m1_writedata  : m0_writedata;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  always_comb begin
    // NOTE: each _d takes its default first, so no branch can leave it unassigned and infer a latch.
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (any_grant) begin
      cs_d    = 1'b1;
      wr_d    = sel_write;
      addr_d  = sel_addr;
      be_d    = sel_write ? sel_be : {BE_W{1'b1}};
      wdata_d = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_chipselect = cs_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = ~reset;

  // Writes enter the pipeline as bubbles so read responses stay in issue order.
  assign tag_new = '{valid: any_grant & ~sel_write, id: win_id};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_new;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // RAM q is valid while the tag sits at CAP_STAGE; the owning master's register captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (tag_q[CAP_STAGE].valid) begin
      if (tag_q[CAP_STAGE].id == 1'b0) begin
        rd0_q <= mem_readdata;
      end else begin
        rd1_q <= mem_readdata;
      end
    end
  end

  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;
  assign m0_readdatavalid = tag_q[READ_LATENCY-1].valid & (tag_q[READ_LATENCY-1].id == 1'b0);
  assign m1_readdatavalid = tag_q[READ_LATENCY-1].valid & (tag_q[READ_LATENCY-1].id == 1'b1);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant0_q, grant1_q, conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      grant0_q   <= sat_inc(grant0_q, grant[0]);
      grant1_q   <= sat_inc(grant1_q, grant[1]);
      conflict_q <= sat_inc(conflict_q, &req);
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench: RAM model plus a transaction-level reference (word memory, per-master response queues).
module tb_onchip_mem_arbiter;

  localparam bit INIT_LAST = 1'b1;
  localparam int LAT       = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  m_read;
  logic [1:0]  m_write;
  logic [14:0] m_addr  [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_wdata [2];
  wire  [1:0]  m_wait;
  wire  [1:0]  m_rdv;
  wire  [31:0] m_rdata [2];

  wire  [14:0] mem_address;
  wire  [3:0]  mem_byteenable;
  wire         mem_chipselect;
  wire         mem_write;
  wire  [31:0] mem_writedata;
  wire         mem_clken;
  wire  [31:0] mem_readdata;

  onchip_mem_arbiter #(
    .ADDR_W   (15),
    .DATA_W   (32),
    .INIT_LAST(INIT_LAST)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .m0_address      (m_addr[0]),
    .m0_byteenable   (m_be[0]),
    .m0_read         (m_read[0]),
    .m0_write        (m_write[0]),
    .m0_writedata    (m_wdata[0]),
    .m0_waitrequest  (m_wait[0]),
    .m0_readdata     (m_rdata[0]),
    .m0_readdatavalid(m_rdv[0]),
    .m1_address      (m_addr[1]),
    .m1_byteenable   (m_be[1]),
    .m1_read         (m_read[1]),
    .m1_write        (m_write[1]),
    .m1_writedata    (m_wdata[1]),
    .m1_waitrequest  (m_wait[1]),
    .m1_readdata     (m_rdata[1]),
    .m1_readdatavalid(m_rdv[1]),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_clken       (mem_clken),
    .mem_readdata    (mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // Single-port RAM: registered address/write, unregistered q.
  logic [31:0] ram [0:32767];
  logic [14:0] ram_raddr_q = '0;
  logic        ram_clear   = 1'b0;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 32768; i++) ram[i] <= '0;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_raddr_q      <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_raddr_q];

  typedef struct {
    logic        active;
    logic        wr;
    logic        both;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  pend_t       pend [2];
  resp_t       exp_q0 [$];
  resp_t       exp_q1 [$];
  logic [31:0] ref_mem [int];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          last_m;
  int          win;
  int          dut_win;
  logic        conflict;
  logic [31:0] got_data [2];
  int          acc_cyc  [2];
  int          rsp_cyc  [2];
  int          n_resp   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic issue(input int m, input logic wr, input logic both, input logic [14:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    pend[m] = '{active: 1'b1, wr: wr, both: both, addr: a, be: be, data: d};
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      m_read[m]  = pend[m].active && (!pend[m].wr || pend[m].both);
      m_write[m] = pend[m].active && pend[m].wr;
      m_addr[m]  = pend[m].addr;
      m_be[m]    = pend[m].be;
      m_wdata[m] = pend[m].data;
    end
  endtask

  task automatic accept(input int m);
    resp_t r;
    acc_cyc[m] = cyc;
    if (pend[m].wr) begin
      ref_mem[int'(pend[m].addr)] = merge(ref_rd(int'(pend[m].addr)), pend[m].data, pend[m].be);
    end else begin
      r.data = ref_rd(int'(pend[m].addr));
      r.due  = cyc + LAT;
      if (m == 0) exp_q0.push_back(r);
      else        exp_q1.push_back(r);
    end
    pend[m].active = 1'b0;
  endtask

  task automatic check_resp(input int m);
    resp_t r;
    logic  exp_v;
    int    n;
    n     = (m == 0) ? exp_q0.size() : exp_q1.size();
    exp_v = 1'b0;
    if (n > 0) begin
      r     = (m == 0) ? exp_q0[0] : exp_q1[0];
      exp_v = (r.due == cyc);
    end
    check($sformatf("m%0d_readdatavalid@%0d", m, cyc), m_rdv[m], exp_v);
    if (exp_v) begin
      check($sformatf("m%0d_readdata@%0d", m, cyc), m_rdata[m], r.data);
      got_data[m] = m_rdata[m];
      rsp_cyc[m]  = cyc;
      n_resp[m]++;
      if (m == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
  endtask

  // One clock: entered and left at posedge+1.
  task automatic cycle();
    logic [1:0] req;
    drive();
    #1;
    win      = -1;
    dut_win  = -1;
    conflict = 1'b0;
    if (reset) begin
      check("clken_in_reset", mem_clken, 1'b0);
    end else begin
      req      = {pend[1].active, pend[0].active};
      conflict = &req;
      if (conflict)    win = 1 - last_m;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      if (win >= 0) last_m = win;
      if (conflict) dut_win = m_wait[0] ? 1 : 0;
      check("m0_waitrequest", m_wait[0], pend[0].active && (win != 0));
      check("m1_waitrequest", m_wait[1], pend[1].active && (win != 1));
      if (win >= 0) accept(win);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      last_m = INIT_LAST;
    end
    check_resp(0);
    check_resp(1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((pend[0].active || pend[1].active || exp_q0.size() > 0 || exp_q1.size() > 0) && n < max_cyc) begin
      cycle();
      n++;
    end
    check("drain_timeout", int'(pend[0].active) + int'(pend[1].active) + exp_q0.size() + exp_q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int base0, base1;
    logic        wr, both;
    logic [14:0] a;
    logic [3:0]  be;

    last_m = INIT_LAST;
    for (int m = 0; m < 2; m++) begin
      pend[m]     = '{active: 1'b0, wr: 1'b0, both: 1'b0, addr: '0, be: '0, data: '0};
      got_data[m] = '0;
      acc_cyc[m]  = 0;
      rsp_cyc[m]  = 0;
      n_resp[m]   = 0;
    end
    drive();
    reset     = 1'b1;
    ram_clear = 1'b1;
    @(posedge clk);
    #1;
    ram_clear = 1'b0;

    // Reset for two cycles, then idle.
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("idle_chipselect", mem_chipselect, 1'b0);
    check("idle_mem_write", mem_write, 1'b0);
    check("idle_clken", mem_clken, 1'b1);
    check("idle_mem_address", mem_address, 15'h0);
    check("idle_mem_be", mem_byteenable, 4'h0);
    check("idle_m0_readdata", m_rdata[0], 32'h0);
    check("idle_m1_readdata", m_rdata[1], 32'h0);

    // Write then read back with fixed latency.
    issue(0, 1'b1, 1'b0, 15'h0010, 4'hF, 32'hDEADBEEF);
    cycle();
    check("wr_chipselect", mem_chipselect, 1'b1);
    check("wr_mem_write", mem_write, 1'b1);
    check("wr_mem_address", mem_address, 15'h0010);
    check("wr_mem_be", mem_byteenable, 4'hF);
    check("wr_mem_writedata", mem_writedata, 32'hDEADBEEF);
    issue(0, 1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
    cycle();
    check("rd_chipselect", mem_chipselect, 1'b1);
    check("rd_mem_write", mem_write, 1'b0);
    drain(10);
    check("rd_data_0010", got_data[0], 32'hDEADBEEF);
    check("rd_latency", rsp_cyc[0] - acc_cyc[0], LAT);
    cycle();
    check("hold_chipselect", mem_chipselect, 1'b0);
    check("hold_mem_address", mem_address, 15'h0010);

    // Contention: both masters keep reading for six cycles.
    issue(1, 1'b1, 1'b0, 15'h0011, 4'hF, 32'h5A5A0001);
    drain(10);
    base0 = n_resp[0];
    base1 = n_resp[1];
    prev  = -1;
    for (int i = 0; i < 6; i++) begin
      if (!pend[0].active) issue(0, 1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
      if (!pend[1].active) issue(1, 1'b0, 1'b0, 15'h0011, 4'h0, 32'h0);
      cycle();
      check("contention_seen", conflict, 1'b1);
      if (i == 0) check("first_winner_m0", dut_win, 0);
      else        check("grant_alternates", dut_win, 1 - prev);
      prev = dut_win;
    end
    pend[0].active = 1'b0;
    pend[1].active = 1'b0;
    drain(10);
    check("contention_m0_responses", n_resp[0] - base0, 3);
    check("contention_m1_responses", n_resp[1] - base1, 3);
    check("contention_m1_data", got_data[1], 32'h5A5A0001);

    // Byte-lane write at the top address, then check address 0 is untouched.
    issue(1, 1'b1, 1'b0, 15'h7FFF, 4'hF, 32'h11223344);
    cycle();
    issue(1, 1'b1, 1'b0, 15'h7FFF, 4'h2, 32'h0000AB00);
    cycle();
    check("byte_wr_be", mem_byteenable, 4'h2);
    issue(1, 1'b0, 1'b0, 15'h7FFF, 4'h2, 32'h0);
    cycle();
    check("rd_be_all_ones", mem_byteenable, 4'hF);
    drain(10);
    check("byte_merge_7fff", got_data[1], 32'h1122AB44);
    issue(1, 1'b0, 1'b0, 15'h0000, 4'h0, 32'h0);
    drain(10);
    check("no_alias_addr0", got_data[1], 32'h0);

    // Read and write together from m0: write only, no response.
    base0 = n_resp[0];
    issue(0, 1'b1, 1'b1, 15'h0020, 4'hF, 32'hCAFEF00D);
    cycle();
    check("rw_mem_write", mem_write, 1'b1);
    check("rw_mem_address", mem_address, 15'h0020);
    for (int i = 0; i < 5; i++) cycle();
    check("rw_no_response", n_resp[0] - base0, 0);
    issue(0, 1'b0, 1'b0, 15'h0020, 4'h0, 32'h0);
    drain(10);
    check("rw_readback", got_data[0], 32'hCAFEF00D);

    // Reset one cycle after a read is accepted: that read never returns.
    base0 = n_resp[0];
    issue(0, 1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check("dropped_read_no_rdv", n_resp[0] - base0, 0);
    issue(0, 1'b0, 1'b0, 15'h0010, 4'h0, 32'h0);
    drain(10);
    check("post_reset_data", got_data[0], 32'hDEADBEEF);
    check("post_reset_latency", rsp_cyc[0] - acc_cyc[0], LAT);

    // Random mixed traffic on a shared window.
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m].active && $urandom_range(0, 3) != 0) begin
          wr   = ($urandom_range(0, 2) == 0);
          both = wr && ($urandom_range(0, 7) == 0);
          a    = 15'(32'h0100 + $urandom_range(0, 15));
          be   = 4'($urandom_range(1, 15));
          issue(m, wr, both, a, be, $urandom);
        end
      end
      cycle();
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
